// File: rtl/alu_issue_stage.sv
// ALU issue stage: field decode, output register plus one-entry skid buffer.
// Optional illegal-encoding detection is enabled by defining ALU_ISSUE_ILLEGAL_DET_EN.
module alu_issue_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] imm_out,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] ex_rs1,
  output logic [31:0] ex_rs2,
  output logic [31:0] ex_imm,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_func3,
  output logic [6:0]  ex_func7,
  output logic [3:0]  alu_ctrl,
  output logic        ex_alu_src,
  output logic        illegal
);

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [3:0]  ctrl;
    logic        src;
    logic        ill;
  } ent_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  ent_t dec;
  logic alt;
  logic f7_ok;

  always_comb begin
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
    alt = (func7 == F7_ALT);
`else
    alt = func7[5];
`endif
    f7_ok = (func7 == 7'b0) || (func7 == F7_ALT);
    dec = '0;
    dec.rs1 = rs1;
    dec.rs2 = rs2;
    dec.imm = imm_out;
    dec.opcode = opcode;
    dec.func3 = func3;
    dec.func7 = func7;
    unique case (func3)
      3'b000: dec.ctrl = (alt && opcode == OP_R) ? 4'b0001 : 4'b0000;
      3'b001: dec.ctrl = 4'b0101;
      3'b010: dec.ctrl = 4'b1000;
      3'b011: dec.ctrl = 4'b1001;
      3'b100: dec.ctrl = 4'b0100;
      3'b101: dec.ctrl = alt ? 4'b0111 : 4'b0110;
      3'b110: dec.ctrl = 4'b0011;
      3'b111: dec.ctrl = 4'b0010;
      default: dec.ctrl = 4'b0000;
    endcase
    // Non-ALU-format opcodes override the func3 map
    case (opcode)
      OP_R: begin
        dec.src = 1'b0;
        dec.ill = !f7_ok ||
          (func7 == F7_ALT && func3 != 3'b000 && func3 != 3'b101);
      end
      OP_I: begin
        dec.src = 1'b1;
        dec.ill = (func3 == 3'b001 || func3 == 3'b101) && !f7_ok;
      end
      OP_LD, OP_ST, OP_JLR, OP_JAL, OP_AUI, OP_LUI: begin
        dec.ctrl = 4'b0000;
        dec.src = 1'b1;
      end
      OP_BR: begin
        dec.ctrl = 4'b0001;
        dec.src = 1'b0;
      end
      default: begin
        dec.ctrl = 4'b0000;
        dec.src = 1'b0;
        dec.ill = 1'b1;
      end
    endcase
`ifndef ALU_ISSUE_ILLEGAL_DET_EN
    dec.ill = 1'b0;
`endif
  end

  ent_t out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic accept, fire;

  assign in_ready = !skid_valid_q;
  assign accept = in_valid && in_ready;
  assign fire = out_valid_q && out_ready;

  always_comb begin
    out_d = out_q;
    skid_d = skid_q;
    out_valid_d = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (fire || !out_valid_q) begin
      if (skid_valid_q) begin
        out_d = skid_q;
        out_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      skid_q <= '0;
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ex_rs1 = out_q.rs1;
  assign ex_rs2 = out_q.rs2;
  assign ex_imm = out_q.imm;
  assign ex_opcode = out_q.opcode;
  assign ex_func3 = out_q.func3;
  assign ex_func7 = out_q.func7;
  assign alu_ctrl = out_q.ctrl;
  assign ex_alu_src = out_q.src;
  assign illegal = out_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: decode table plus handshake sequences.
// Illegal expectations follow ALU_ISSUE_ILLEGAL_DET_EN when compiled with it.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2, imm_out;
  logic        flush, out_valid, out_ready;
  logic [31:0] ex_rs1, ex_rs2, ex_imm;
  logic [6:0]  ex_opcode, ex_func7;
  logic [2:0]  ex_func3;
  logic [3:0]  alu_ctrl;
  logic        ex_alu_src, illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .func7(func7),
    .rs1(rs1), .rs2(rs2), .imm_out(imm_out),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
    .ex_opcode(ex_opcode), .ex_func3(ex_func3), .ex_func7(ex_func7),
    .alu_ctrl(alu_ctrl), .ex_alu_src(ex_alu_src), .illegal(illegal)
  );

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] ctrl;
    logic       src;
    logic       ill;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [3:0] c,
                     input logic s, input logic il);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.ctrl = c; v.src = s;
`ifdef ALU_ISSUE_ILLEGAL_DET_EN
    v.ill = il;
`else
    v.ill = 1'b0 & il;
`endif
    vt.push_back(v);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a);
    in_valid = 1'b1;
    opcode = 7'b0110011; func3 = 3'b000; func7 = 7'b0;
    rs1 = a; rs2 = ~a; imm_out = a + 1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; flush = 0; out_ready = 1;
    opcode = 0; func3 = 0; func7 = 0; rs1 = 0; rs2 = 0; imm_out = 0;
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_alu_ctrl", {28'b0, alu_ctrl}, 0);
    chk("rst_src", {31'b0, ex_alu_src}, 0);
    chk("rst_illegal", {31'b0, illegal}, 0);
    chk("rst_ex_rs1", ex_rs1, 0);
    chk("rst_ex_imm", ex_imm, 0);
    @(negedge clk);
    rst = 1'b0;
    tick;

    add(7'h33, 3'b000, 7'h20, 4'b0001, 0, 0);
    add(7'h33, 3'b000, 7'h00, 4'b0000, 0, 0);
    add(7'h33, 3'b001, 7'h00, 4'b0101, 0, 0);
    add(7'h33, 3'b010, 7'h00, 4'b1000, 0, 0);
    add(7'h33, 3'b011, 7'h00, 4'b1001, 0, 0);
    add(7'h33, 3'b100, 7'h00, 4'b0100, 0, 0);
    add(7'h33, 3'b101, 7'h00, 4'b0110, 0, 0);
    add(7'h33, 3'b101, 7'h20, 4'b0111, 0, 0);
    add(7'h33, 3'b110, 7'h00, 4'b0011, 0, 0);
    add(7'h33, 3'b111, 7'h00, 4'b0010, 0, 0);
    add(7'h33, 3'b000, 7'h01, 4'b0000, 0, 1);
    add(7'h33, 3'b111, 7'h20, 4'b0010, 0, 1);
    add(7'h13, 3'b101, 7'h20, 4'b0111, 1, 0);
    add(7'h13, 3'b000, 7'h20, 4'b0000, 1, 0);
    add(7'h13, 3'b001, 7'h00, 4'b0101, 1, 0);
    add(7'h13, 3'b010, 7'h00, 4'b1000, 1, 0);
    add(7'h13, 3'b011, 7'h00, 4'b1001, 1, 0);
    add(7'h13, 3'b100, 7'h00, 4'b0100, 1, 0);
    add(7'h13, 3'b110, 7'h00, 4'b0011, 1, 0);
    add(7'h13, 3'b111, 7'h00, 4'b0010, 1, 0);
    add(7'h13, 3'b001, 7'h01, 4'b0101, 1, 1);
    add(7'h03, 3'b010, 7'h00, 4'b0000, 1, 0);
    add(7'h23, 3'b010, 7'h00, 4'b0000, 1, 0);
    add(7'h67, 3'b000, 7'h00, 4'b0000, 1, 0);
    add(7'h6f, 3'b111, 7'h20, 4'b0000, 1, 0);
    add(7'h17, 3'b101, 7'h00, 4'b0000, 1, 0);
    add(7'h37, 3'b100, 7'h20, 4'b0000, 1, 0);
    add(7'h63, 3'b001, 7'h00, 4'b0001, 0, 0);
    add(7'h7f, 3'b000, 7'h00, 4'b0000, 0, 1);
    add(7'h00, 3'b010, 7'h20, 4'b0000, 0, 1);

    foreach (vt[i]) begin
      in_valid = 1'b1;
      opcode = vt[i].op; func3 = vt[i].f3; func7 = vt[i].f7;
      rs1 = 32'h1000_0000 + i; rs2 = ~rs1; imm_out = i * 3;
      chk("vec_in_ready", {31'b0, in_ready}, 1);
      tick;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 1);
      chk($sformatf("v%0d_ctrl", i), {28'b0, alu_ctrl}, {28'b0, vt[i].ctrl});
      chk($sformatf("v%0d_src", i), {31'b0, ex_alu_src}, {31'b0, vt[i].src});
      chk($sformatf("v%0d_ill", i), {31'b0, illegal}, {31'b0, vt[i].ill});
      chk($sformatf("v%0d_rs1", i), ex_rs1, 32'h1000_0000 + i);
      chk($sformatf("v%0d_rs2", i), ex_rs2, ~(32'h1000_0000 + i));
      chk($sformatf("v%0d_imm", i), ex_imm, i * 3);
      chk($sformatf("v%0d_fields", i), {15'b0, ex_opcode, ex_func3, ex_func7},
          {15'b0, vt[i].op, vt[i].f3, vt[i].f7});
    end
    in_valid = 0;
    tick;
    chk("drain_valid", {31'b0, out_valid}, 0);

    // backpressure: A then B, B sits in skid until release
    out_ready = 0;
    put(32'hA);
    tick;
    chk("bp_a_valid", {31'b0, out_valid}, 1);
    chk("bp_a_rs1", ex_rs1, 32'hA);
    put(32'hB);
    tick;
    in_valid = 0;
    chk("bp_in_ready0", {31'b0, in_ready}, 0);
    chk("bp_hold_a", ex_rs1, 32'hA);
    tick;
    chk("bp_hold_a2", ex_rs1, 32'hA);
    chk("bp_hold_imm", ex_imm, 32'hB);
    out_ready = 1;
    tick;
    chk("bp_b_rs1", ex_rs1, 32'hB);
    chk("bp_b_valid", {31'b0, out_valid}, 1);
    chk("bp_in_ready1", {31'b0, in_ready}, 1);
    tick;
    chk("bp_empty", {31'b0, out_valid}, 0);

    // flush with skid full and a same-cycle input
    out_ready = 0;
    put(32'hC1);
    tick;
    put(32'hC2);
    tick;
    chk("fl_full", {31'b0, in_ready}, 0);
    put(32'hC3);
    flush = 1;
    tick;
    flush = 0; in_valid = 0;
    chk("fl_valid", {31'b0, out_valid}, 0);
    chk("fl_in_ready", {31'b0, in_ready}, 1);
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("fl_no_emerge", {31'b0, out_valid}, 0);
    end

    // async reset with skid full
    out_ready = 0;
    put(32'hD1);
    tick;
    put(32'hD2);
    tick;
    in_valid = 0;
    chk("rr_full", {31'b0, in_ready}, 0);
    @(negedge clk);
    #1 rst = 1;
    #1;
    chk("rr_out_valid", {31'b0, out_valid}, 0);
    chk("rr_in_ready", {31'b0, in_ready}, 1);
    chk("rr_ex_rs1", ex_rs1, 0);
    @(negedge clk);
    rst = 0;
    out_ready = 1;
    put(32'hE);
    tick;
    in_valid = 0;
    chk("rr_first_acc", {31'b0, out_valid}, 1);
    chk("rr_first_rs1", ex_rs1, 32'hE);
    tick;
    chk("rr_done", {31'b0, out_valid}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
